// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: op codes, FSM states and the iterative-op decode.
package seq_alu_pkg;

   localparam logic [3:0] OP_AND  = 4'h0;
   localparam logic [3:0] OP_OR   = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_MOD  = 4'h3;
   localparam logic [3:0] OP_NOR  = 4'h4;
   localparam logic [3:0] OP_MUL  = 4'h5;
   localparam logic [3:0] OP_SUB  = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   localparam logic [3:0] OP_DIV  = 4'h8;
   localparam logic [3:0] OP_SLTU = 4'h9;
   localparam logic [3:0] OP_ILL  = 4'hA;
   localparam logic [3:0] OP_SLTS = 4'hB;
   localparam logic [3:0] OP_NOT  = 4'hC;
   localparam logic [3:0] OP_EQ   = 4'hD;
   localparam logic [3:0] OP_LUI  = 4'hE;
   localparam logic [3:0] OP_ZERO = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Divide/modulo by zero short-circuits to the single-cycle path.
   function automatic logic is_iter(input logic [3:0] op, input logic b_zero);
      return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && !b_zero);
   endfunction

endpackage

// File: rtl/seq_alu_iter_muldiv.sv
// Iterative multiplier / restoring divider, one bit per cycle over WIDTH cycles.
module seq_alu_iter_muldiv
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] prod,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic             busy_q;
   logic             div_q;
   logic [CW-1:0]    cnt_q;
   // x: multiplicand / divisor, y: multiplier / dividend-to-quotient, r: product / remainder
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      r_d     = r_q;
      shifted = {r_q, y_q[WIDTH-1]};
      diff    = shifted - {1'b0, x_q};
      if (div_q) begin
         if (diff[WIDTH]) begin
            r_d = shifted[WIDTH-1:0];
            y_d = {y_q[WIDTH-2:0], 1'b0};
         end else begin
            r_d = diff[WIDTH-1:0];
            y_d = {y_q[WIDTH-2:0], 1'b1};
         end
      end else begin
         r_d = r_q + (y_q[0] ? x_q : '0);
         x_d = x_q << 1;
         y_d = y_q >> 1;
      end
   end

   // Results are the next-state values so the caller can capture them on the last step.
   assign done = busy_q && (cnt_q == LAST);
   assign prod = r_d;
   assign quot = y_d;
   assign rem  = r_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
         x_q    <= '0;
         y_q    <= '0;
         r_q    <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         div_q  <= div;
         cnt_q  <= '0;
         x_q    <= b;
         y_q    <= a;
         r_q    <= '0;
      end else if (busy_q) begin
         x_q   <= x_d;
         y_q   <= y_d;
         r_q   <= r_d;
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle registered ALU with valid/ready handshakes on both sides.
// Optional cf/of/nf flag outputs are enabled by defining SEQ_ALU_FLAGS_EN.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned LUI_SHIFT = WIDTH / 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             zf,
   output logic             dz,
   output logic             illegal
`ifdef SEQ_ALU_FLAGS_EN
   ,
   output logic             cf,
   output logic             of,
   output logic             nf
`endif
);

   state_e           state_q;
   logic [3:0]       op_q;
   logic             accept;
   logic             start;
   logic             b_zero;
   logic [WIDTH-1:0] res_c;
   logic             dz_c;
   logic             ill_c;
   logic             md_done;
   logic [WIDTH-1:0] md_prod;
   logic [WIDTH-1:0] md_quot;
   logic [WIDTH-1:0] md_rem;
   logic [WIDTH-1:0] md_res;

   // Extra top bit carries ADD carry-out / SUB borrow when flags are built in.
`ifdef SEQ_ALU_FLAGS_EN
   logic [WIDTH:0]   add_x;
   logic [WIDTH:0]   sub_x;
   logic             cf_c;
   logic             of_c;
   assign add_x = {1'b0, a} + {1'b0, b};
   assign sub_x = {1'b0, a} - {1'b0, b};
`else
   logic [WIDTH-1:0] add_x;
   logic [WIDTH-1:0] sub_x;
   assign add_x = a + b;
   assign sub_x = a - b;
`endif

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign accept    = in_valid && in_ready;
   assign b_zero    = (b == '0);
   assign start     = accept && is_iter(sel, b_zero);

   always_comb begin
      res_c = '0;
      dz_c  = 1'b0;
      ill_c = 1'b0;
      case (sel)
         OP_AND:  res_c = a & b;
         OP_OR:   res_c = a | b;
         OP_ADD:  res_c = add_x[WIDTH-1:0];
         OP_MOD: begin
            res_c = a;
            dz_c  = b_zero;
         end
         OP_NOR:  res_c = ~(a | b);
         OP_MUL:  res_c = '0;
         OP_SUB:  res_c = sub_x[WIDTH-1:0];
         OP_XOR:  res_c = a ^ b;
         OP_DIV: begin
            res_c = '1;
            dz_c  = b_zero;
         end
         OP_SLTU: res_c = WIDTH'(a < b);
         OP_ILL:  ill_c = 1'b1;
         OP_SLTS: res_c = WIDTH'($signed(a) < $signed(b));
         OP_NOT:  res_c = ~b;
         OP_EQ:   res_c = WIDTH'(a == b);
         OP_LUI:  res_c = b << LUI_SHIFT;
         OP_ZERO: res_c = '0;
         default: res_c = '0;
      endcase
   end

`ifdef SEQ_ALU_FLAGS_EN
   always_comb begin
      cf_c = 1'b0;
      of_c = 1'b0;
      if (sel == OP_ADD) begin
         cf_c = add_x[WIDTH];
         of_c = (a[WIDTH-1] == b[WIDTH-1]) && (add_x[WIDTH-1] != a[WIDTH-1]);
      end else if (sel == OP_SUB) begin
         cf_c = sub_x[WIDTH];
         of_c = (a[WIDTH-1] != b[WIDTH-1]) && (sub_x[WIDTH-1] != a[WIDTH-1]);
      end
   end
`endif

   seq_alu_iter_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .div   (sel != OP_MUL),
      .a     (a),
      .b     (b),
      .done  (md_done),
      .prod  (md_prod),
      .quot  (md_quot),
      .rem   (md_rem)
   );

   always_comb begin
      case (op_q)
         OP_MUL:  md_res = md_prod;
         OP_DIV:  md_res = md_quot;
         default: md_res = md_rem;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         res     <= '0;
         zf      <= 1'b0;
         dz      <= 1'b0;
         illegal <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
         cf      <= 1'b0;
         of      <= 1'b0;
         nf      <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q <= sel;
                  if (start) begin
                     state_q <= ST_BUSY;
                  end else begin
                     state_q <= ST_DONE;
                     res     <= res_c;
                     zf      <= (res_c == '0);
                     dz      <= dz_c;
                     illegal <= ill_c;
`ifdef SEQ_ALU_FLAGS_EN
                     cf      <= cf_c;
                     of      <= of_c;
                     nf      <= res_c[WIDTH-1];
`endif
                  end
               end
            end
            ST_BUSY: begin
               if (md_done) begin
                  state_q <= ST_DONE;
                  res     <= md_res;
                  zf      <= (md_res == '0);
                  dz      <= 1'b0;
                  illegal <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
                  cf      <= 1'b0;
                  of      <= 1'b0;
                  nf      <= md_res[WIDTH-1];
`endif
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); flag checks follow SEQ_ALU_FLAGS_EN.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  sel;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] res;
   logic        zf;
   logic        dz;
   logic        illegal;
`ifdef SEQ_ALU_FLAGS_EN
   logic        cf;
   logic        of;
   logic        nf;
   logic        got_cf, got_of, got_nf;
`endif

   int          errors = 0;
   int          checks = 0;
   int          lat;
   int          lowcnt;
   logic [31:0] got_res;
   logic        got_zf, got_dz, got_ill;

   always #5 clk = ~clk;

   seq_alu dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .zf        (zf),
      .dz        (dz),
      .illegal   (illegal)
`ifdef SEQ_ALU_FLAGS_EN
      ,
      .cf        (cf),
      .of        (of),
      .nf        (nf)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op with out_ready high and record latency, busy span and the result.
   task automatic run(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
      logic seen;
      in_valid = 1'b1;
      sel      = s;
      a        = x;
      b        = y;
      tick();
      in_valid = 1'b0;
      seen     = 1'b0;
      lat      = 0;
      lowcnt   = 0;
      got_res  = 'x;
      got_zf   = 1'bx;
      got_dz   = 1'bx;
      got_ill  = 1'bx;
      while (!in_ready && lowcnt < 200) begin
         lowcnt++;
         if (out_valid && !seen) begin
            seen    = 1'b1;
            lat     = lowcnt;
            got_res = res;
            got_zf  = zf;
            got_dz  = dz;
            got_ill = illegal;
`ifdef SEQ_ALU_FLAGS_EN
            got_cf  = cf;
            got_of  = of;
            got_nf  = nf;
`endif
         end
         tick();
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      sel       = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_res", res, 32'd0);
      chk("rst_zf", 32'(zf), 32'd0);
      chk("rst_dz", 32'(dz), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      out_ready = 1'b1;

      run(4'h2, 32'hFFFF_FFFF, 32'd1);
      chk("add_wrap_lat", 32'(lat), 32'd1);
      chk("add_wrap_res", got_res, 32'd0);
      chk("add_wrap_zf", 32'(got_zf), 32'd1);
`ifdef SEQ_ALU_FLAGS_EN
      chk("add_wrap_cf", 32'(got_cf), 32'd1);
      chk("add_wrap_of", 32'(got_of), 32'd0);
      run(4'h2, 32'h7FFF_FFFF, 32'd1);
      chk("add_ovf_of", 32'(got_of), 32'd1);
      chk("add_ovf_cf", 32'(got_cf), 32'd0);
      chk("add_ovf_nf", 32'(got_nf), 32'd1);
      run(4'h6, 32'd3, 32'd5);
      chk("sub_borrow_cf", 32'(got_cf), 32'd1);
      chk("sub_borrow_of", 32'(got_of), 32'd0);
`endif

      run(4'h8, 32'd100, 32'd7);
      chk("div_busy_span", 32'(lowcnt), 32'd33);
      chk("div_lat", 32'(lat), 32'd33);
      chk("div_res", got_res, 32'd14);
      chk("div_dz", 32'(got_dz), 32'd0);
      run(4'h3, 32'd100, 32'd7);
      chk("mod_res", got_res, 32'd2);
      chk("mod_dz", 32'(got_dz), 32'd0);
      chk("mod_lat", 32'(lat), 32'd33);

      run(4'h8, 32'd5, 32'd0);
      chk("div0_lat", 32'(lat), 32'd1);
      chk("div0_res", got_res, 32'hFFFF_FFFF);
      chk("div0_dz", 32'(got_dz), 32'd1);
      run(4'h3, 32'd5, 32'd0);
      chk("mod0_res", got_res, 32'd5);
      chk("mod0_dz", 32'(got_dz), 32'd1);

      run(4'h5, 32'h0001_0000, 32'h0001_0000);
      chk("mul_wrap_lat", 32'(lat), 32'd33);
      chk("mul_wrap_res", got_res, 32'd0);
      chk("mul_wrap_zf", 32'(got_zf), 32'd1);
      run(4'h5, 32'd12345, 32'd6789);
      chk("mul_res", got_res, 32'd83810205);
      run(4'h8, 32'hFFFF_FFFF, 32'd16);
      chk("div_big_res", got_res, 32'h0FFF_FFFF);
      run(4'h3, 32'd1000, 32'd3);
      chk("mod_small_res", got_res, 32'd1);

      run(4'hB, 32'hFFFF_FFFF, 32'd1);
      chk("slts_res", got_res, 32'd1);
      run(4'h9, 32'hFFFF_FFFF, 32'd1);
      chk("sltu_res", got_res, 32'd0);
      chk("sltu_zf", 32'(got_zf), 32'd1);
      run(4'h6, 32'd3, 32'd5);
      chk("sub_res", got_res, 32'hFFFF_FFFE);
      run(4'h0, 32'hF0F0_1234, 32'h0FF0_FF00);
      chk("and_res", got_res, 32'h00F0_1200);
      run(4'h1, 32'hF000_0001, 32'h0000_0F10);
      chk("or_res", got_res, 32'hF000_0F11);
      run(4'h4, 32'hF000_0001, 32'h0000_0F10);
      chk("nor_res", got_res, 32'h0FFF_F0EE);
      run(4'h7, 32'hAAAA_5555, 32'hFFFF_0000);
      chk("xor_res", got_res, 32'h5555_5555);
      run(4'hC, 32'd0, 32'h1234_5678);
      chk("not_res", got_res, 32'hEDCB_A987);
      run(4'hD, 32'd77, 32'd77);
      chk("eq_res", got_res, 32'd1);
      run(4'hF, 32'd9, 32'd9);
      chk("zero_res", got_res, 32'd0);
      run(4'hA, 32'd5, 32'd5);
      chk("ill_lat", 32'(lat), 32'd1);
      chk("ill_res", got_res, 32'd0);
      chk("ill_zf", 32'(got_zf), 32'd1);
      chk("ill_flag", 32'(got_ill), 32'd1);
      run(4'hE, 32'd0, 32'h0000_1234);
      chk("lui_res", got_res, 32'h1234_0000);
      chk("lui_ill", 32'(got_ill), 32'd0);

      // Back-pressure: result held, new requests ignored while DONE.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      sel       = 4'h2;
      a         = 32'd2;
      b         = 32'd3;
      tick();
      sel = 4'h6;
      a   = 32'd9;
      b   = 32'd1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_res", res, 32'd5);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_res_final", res, 32'd5);
      tick();
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);

      // Reset in the middle of a divide.
      in_valid = 1'b1;
      sel      = 4'h8;
      a        = 32'd100;
      b        = 32'd7;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("mid_busy_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_res", res, 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_dz", 32'(dz), 32'd0);
      run(4'h8, 32'd100, 32'd7);
      chk("post_abort_div_res", got_res, 32'd14);
      chk("post_abort_div_lat", 32'(lat), 32'd33);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
